// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the debounce_pulse block.
//   state_t              : debouncer FSM state encoding
//   SYNC_STAGES_MIN/MAX  : legal synchronizer depth
//   DEBOUNCE_CYCLES_MIN/MAX : legal debounce length (stable samples)
// ---------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;
    localparam int DEBOUNCE_CYCLES_MIN = 2;
    localparam int DEBOUNCE_CYCLES_MAX = 1 << 20;

endpackage

// File: rtl/debounce_pulse_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// All stages clear to 0 on reset.
// Parameters:
//   STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   i_d  : asynchronous input level
//   o_q  : synchronized level (output of the last flop)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    // Keep the chain together and away from retiming in the fabric.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_sync[0] <= 1'b0;
                    else     r_sync[0] <= i_d;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) r_sync[gi] <= 1'b0;
                    else     r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// ---------------------------------------------------------------------------
// debounce_pulse
// Synchronizes and debounces a raw asynchronous input. A new level is accepted
// only after DEBOUNCE_CYCLES consecutive clock edges sample it; on acceptance
// level_out follows and a one-cycle pulse_rise / pulse_fall is emitted.
//
// Parameters:
//   SYNC_STAGES     : synchronizer depth (2..4)
//   DEBOUNCE_CYCLES : consecutive stable samples to accept a change (2..2^20)
//   INVERT_IN       : 1 inverts sig_in before synchronization
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   sig_in     : asynchronous raw input
//   level_out  : debounced level (registered)
//   pulse_rise : one-cycle pulse on each accepted 0->1 change
//   pulse_fall : one-cycle pulse on each accepted 1->0 change
//   evt_clr    : (DEBOUNCE_PULSE_EVT_CNT_EN only) clear the event counter
//   evt_cnt    : (DEBOUNCE_PULSE_EVT_CNT_EN only) saturating count of rises
//
// Optional feature: define DEBOUNCE_PULSE_EVT_CNT_EN to add the rise event
// counter and its two ports.
// ---------------------------------------------------------------------------
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int INVERT_IN       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    output logic        level_out,
    output logic        pulse_rise,
    output logic        pulse_fall
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
    ,
    input  logic        evt_clr,
    output logic [15:0] evt_cnt
`endif
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
            $error("debounce_pulse: SYNC_STAGES out of range");
        end
        if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN ||
            DEBOUNCE_CYCLES > DEBOUNCE_CYCLES_MAX) begin : g_bad_deb
            $error("debounce_pulse: DEBOUNCE_CYCLES out of range");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input conditioning and synchronizer
    // ------------------------------------------------------------------
    logic w_sig_raw;
    logic w_sig_s;

    assign w_sig_raw = (INVERT_IN != 0) ? ~sig_in : sig_in;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (w_sig_raw),
        .o_q (w_sig_s)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_level, w_level_next;
    logic             r_rise,  w_rise_next;
    logic             r_fall,  w_fall_next;

    // State register; outputs are registered alongside so the pulse lines up
    // with the first cycle spent in the new stable state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
            r_count <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
        end
    end

    // Next-state logic. The entry edge into a *_CHK state counts as sample 1,
    // so the change is accepted on the edge that sees count == N-1; the counter
    // therefore never exceeds N-1 and cannot wrap.
    always_comb begin
        w_state_next = r_state;
        w_count_next = '0;
        unique case (r_state)
            S_LOW: begin
                if (w_sig_s) begin
                    w_state_next = S_RISE_CHK;
                    w_count_next = CNT_ONE;
                end
            end
            S_RISE_CHK: begin
                if (!w_sig_s) begin
                    w_state_next = S_LOW;
                end else if (r_count == CNT_LAST) begin
                    w_state_next = S_HIGH;
                end else begin
                    w_count_next = r_count + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!w_sig_s) begin
                    w_state_next = S_FALL_CHK;
                    w_count_next = CNT_ONE;
                end
            end
            S_FALL_CHK: begin
                if (w_sig_s) begin
                    w_state_next = S_HIGH;
                end else if (r_count == CNT_LAST) begin
                    w_state_next = S_LOW;
                end else begin
                    w_count_next = r_count + CNT_ONE;
                end
            end
            default: begin
                w_state_next = S_LOW;
            end
        endcase
    end

    // Output logic: pulses fire only on a completed check, never on a glitch
    // returning to the original stable state.
    always_comb begin
        w_rise_next  = (r_state == S_RISE_CHK) && (w_state_next == S_HIGH);
        w_fall_next  = (r_state == S_FALL_CHK) && (w_state_next == S_LOW);
        w_level_next = r_level;
        if (w_rise_next) w_level_next = 1'b1;
        if (w_fall_next) w_level_next = 1'b0;
    end

    assign level_out  = r_level;
    assign pulse_rise = r_rise;
    assign pulse_fall = r_fall;

    // ------------------------------------------------------------------
    // Optional rise event counter
    // ------------------------------------------------------------------
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
    logic [15:0] r_evt_cnt;

    // Counts the cycles in which pulse_rise is high; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || evt_clr) begin
            r_evt_cnt <= '0;
        end else if (r_rise && (r_evt_cnt != 16'hFFFF)) begin
            r_evt_cnt <= r_evt_cnt + 16'd1;
        end
    end

    assign evt_cnt = r_evt_cnt;
`endif

endmodule

// File: tb/tb_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_debounce_pulse
// Bench for debounce_pulse with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Every cycle the DUT outputs are compared against a reference model that
// works from the raw input history: the synchronized value seen at edge n is
// the raw input of edge n-SYNC_STAGES (0 if a reset edge lies in between), and
// a change is accepted when the last DEBOUNCE_CYCLES samples since the last
// reset/acceptance all differ from the current level.
// ---------------------------------------------------------------------------
module tb_debounce_pulse;

    localparam int S    = 2;
    localparam int D    = 4;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst;
    logic sig_in;
    logic level_out;
    logic pulse_rise;
    logic pulse_fall;
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
    logic        evt_clr;
    logic [15:0] evt_cnt;
    int          m_evt;
`endif

    always #5 clk = ~clk;

    debounce_pulse #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .INVERT_IN       (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .level_out  (level_out),
        .pulse_rise (pulse_rise),
        .pulse_fall (pulse_fall)
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
        ,
        .evt_clr    (evt_clr),
        .evt_cnt    (evt_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int n        = 0;
    int last_evt = -1;
    bit raw_a  [HMAX];
    bit rst_a  [HMAX];
    bit samp_a [HMAX];
    bit m_level = 1'b0;
    bit m_rise  = 1'b0;
    bit m_fall  = 1'b0;

    function automatic bit sig_s_at(int e);
        if (e < S) return 1'b0;
        for (int i = e - S; i < e; i++) begin
            if (rst_a[i]) return 1'b0;
        end
        return raw_a[e - S];
    endfunction

    task automatic model_edge(input bit r, input bit s);
        bit ok;
        if (n >= HMAX) begin
            $display("FAIL history_overflow edge %0d limit %0d", n, HMAX);
            errors++;
            $fatal(1, "history overflow");
        end
        raw_a[n] = s;
        rst_a[n] = r;
        if (r) begin
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
            m_evt = 0;
`endif
            last_evt = n;
            m_level  = 1'b0;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
        end else begin
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
            if (evt_clr)                      m_evt = 0;
            else if (m_rise && m_evt < 65535) m_evt = m_evt + 1;
`endif
            samp_a[n] = sig_s_at(n);
            ok = (n - D + 1) > last_evt;
            if (ok) begin
                for (int i = n - D + 1; i <= n; i++) begin
                    if (samp_a[i] == m_level) ok = 1'b0;
                end
            end
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (ok) begin
                m_level  = !m_level;
                m_rise   = m_level;
                m_fall   = !m_level;
                last_evt = n;
            end
        end
        n++;
    endtask

    // One clock edge: drive, advance model, sample at the falling edge.
    task automatic cyc(input bit r, input bit s);
        rst    = r;
        sig_in = s;
        @(posedge clk);
        model_edge(r, s);
        @(negedge clk);
        checks++;
        if (level_out !== m_level || pulse_rise !== m_rise || pulse_fall !== m_fall) begin
            errors++;
            $display("FAIL model edge %0d got lvl/rise/fall %b%b%b expected %b%b%b",
                     n - 1, level_out, pulse_rise, pulse_fall, m_level, m_rise, m_fall);
        end
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
        checks++;
        if (evt_cnt !== 16'(m_evt)) begin
            errors++;
            $display("FAIL evt_cnt edge %0d got %0d expected %0d", n - 1, evt_cnt, m_evt);
        end
`endif
    endtask

    task automatic expect_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    // ---------------- segment table ----------------
    typedef struct {
        bit r;
        bit s;
        int len;
        bit exp_level;
        int exp_rise;
        int exp_fall;
    } seg_t;

    seg_t segs [15];
    int   n_rise, n_fall;
    int   rlen;
    bit   rs, rr;

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
        evt_clr = 1'b0;
        m_evt   = 0;
`endif
        //            r  s  len lvl rise fall
        segs[0]  = '{1, 0,  3,  0,  0,  0};  // reset
        segs[1]  = '{0, 0,  5,  0,  0,  0};  // idle low
        segs[2]  = '{0, 1,  3,  0,  0,  0};  // 3-cycle high: rejected
        segs[3]  = '{0, 0,  6,  0,  0,  0};
        segs[4]  = '{0, 1,  4,  0,  0,  0};  // 4-cycle high: pulse lands next seg
        segs[5]  = '{0, 0,  8,  0,  1,  1};  // rise then debounced fall
        segs[6]  = '{0, 1, 10,  1,  1,  0};  // clean rise
        segs[7]  = '{0, 0,  2,  1,  0,  0};  // chatter while high
        segs[8]  = '{0, 1,  2,  1,  0,  0};
        segs[9]  = '{0, 0,  3,  1,  0,  0};
        segs[10] = '{0, 1,  6,  1,  0,  0};
        segs[11] = '{0, 0, 10,  0,  0,  1};  // clean fall
        segs[12] = '{1, 1,  2,  0,  0,  0};  // reset with input high
        segs[13] = '{0, 1,  8,  1,  1,  0};  // high at release: normal rise
        segs[14] = '{1, 0,  2,  0,  0,  0};  // reset clears level, no fall pulse

        for (int g = 0; g < 15; g++) begin
            n_rise = 0;
            n_fall = 0;
            for (int k = 0; k < segs[g].len; k++) begin
                cyc(segs[g].r, segs[g].s);
                if (pulse_rise === 1'b1) n_rise++;
                if (pulse_fall === 1'b1) n_fall++;
            end
            checks++;
            if (level_out !== segs[g].exp_level) begin
                errors++;
                $display("FAIL seg%0d_level got %b expected %b", g, level_out, segs[g].exp_level);
            end
            checks++;
            if (n_rise != segs[g].exp_rise) begin
                errors++;
                $display("FAIL seg%0d_rises got %0d expected %0d", g, n_rise, segs[g].exp_rise);
            end
            checks++;
            if (n_fall != segs[g].exp_fall) begin
                errors++;
                $display("FAIL seg%0d_falls got %0d expected %0d", g, n_fall, segs[g].exp_fall);
            end
            $display("seg %0d r=%0b s=%0b len=%0d level=%b rises=%0d falls=%0d",
                     g, segs[g].r, segs[g].s, segs[g].len, level_out, n_rise, n_fall);
        end

        // Clean rise: first sampled high at edge k -> pulse after edge k+5.
        cyc(1, 0);
        expect_bit("reset_level", level_out, 1'b0);
        expect_bit("reset_rise", pulse_rise, 1'b0);
        expect_bit("reset_fall", pulse_fall, 1'b0);
        for (int j = 0; j < 10; j++) cyc(0, 0);
        for (int j = 0; j < 10; j++) begin
            cyc(0, 1);
            expect_bit($sformatf("rise_pulse_j%0d", j), pulse_rise, (j == 5));
            expect_bit($sformatf("rise_level_j%0d", j), level_out, (j >= 5));
        end
        // Clean fall with the same latency.
        for (int j = 0; j < 10; j++) begin
            cyc(0, 0);
            expect_bit($sformatf("fall_pulse_j%0d", j), pulse_fall, (j == 5));
            expect_bit($sformatf("fall_level_j%0d", j), level_out, (j < 5));
        end
        $display("directed clean rise/fall done");

        // Reset mid-debounce (count=2), input held high throughout.
        cyc(1, 0);
        cyc(1, 0);
        for (int j = 0; j < 4; j++) cyc(0, 1);
        for (int j = 0; j < 3; j++) begin
            cyc(1, 1);
            expect_bit($sformatf("midrst_rise_j%0d", j), pulse_rise, 1'b0);
            expect_bit($sformatf("midrst_level_j%0d", j), level_out, 1'b0);
        end
        for (int j = 0; j < 8; j++) begin
            cyc(0, 1);
            expect_bit($sformatf("postrst_rise_j%0d", j), pulse_rise, (j == 5));
        end
        $display("directed mid-debounce reset done");

        // Randomized runs of random length with occasional resets.
        rlen = 0;
        for (int it = 0; it < 2500; it += rlen) begin
            rs   = 1'($urandom_range(0, 1));
            rlen = $urandom_range(1, 8);
            rr   = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < rlen; k++) begin
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
                evt_clr = ($urandom_range(0, 63) == 0);
`endif
                cyc(rr && (k < 2), rs);
            end
        end
`ifdef DEBOUNCE_PULSE_EVT_CNT_EN
        evt_clr = 1'b0;
`endif
        $display("random phase done at edge %0d", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
